// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor.
// The master drives start and the operands; the slave returns status and the result.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// Operands are captured on start in IDLE; the result is held until the next completion.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            r_state;
    logic [WIDTH-1:0]  r_a_sh;
    logic [WIDTH-1:0]  r_b_sh;
    logic [WIDTH-1:0]  r_r_sh;
    logic              r_br;
    logic [CntW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_diff;
    logic              r_borrow;
    logic              r_ovf;

    state_e            w_state_next;
    logic [WIDTH-1:0]  w_a_next;
    logic [WIDTH-1:0]  w_b_next;
    logic [WIDTH-1:0]  w_r_next;
    logic              w_br_next;
    logic [CntW-1:0]   w_cnt_next;
    logic [WIDTH-1:0]  w_diff_next;
    logic              w_borrow_next;
    logic              w_ovf_next;

    logic              w_d;
    logic              w_br;
    logic [WIDTH-1:0]  w_r_sh;

    // Full-subtractor cell on the current LSBs.
    assign w_d    = r_a_sh[0] ^ r_b_sh[0] ^ r_br;
    assign w_br   = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_br);
    assign w_r_sh = (r_r_sh >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

    always_comb begin
        w_state_next  = r_state;
        w_a_next      = r_a_sh;
        w_b_next      = r_b_sh;
        w_r_next      = r_r_sh;
        w_br_next     = r_br;
        w_cnt_next    = r_cnt;
        w_diff_next   = r_diff;
        w_borrow_next = r_borrow;
        w_ovf_next    = r_ovf;
        case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_a_next     = bus.a;
                    w_b_next     = bus.b;
                    w_br_next    = 1'b0;
                    w_cnt_next   = '0;
                    w_state_next = StShift;
                end
            end
            StShift: begin
                w_a_next   = r_a_sh >> 1;
                w_b_next   = r_b_sh >> 1;
                w_r_next   = w_r_sh;
                w_br_next  = w_br;
                w_cnt_next = r_cnt + CntW'(1);
                // On the MSB bit the shift LSBs hold the original operand sign bits.
                if (r_cnt == CntW'(WIDTH - 1)) begin
                    w_diff_next   = w_r_sh;
                    w_borrow_next = w_br;
                    w_ovf_next    = (r_a_sh[0] != r_b_sh[0]) && (w_d != r_a_sh[0]);
                    w_state_next  = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_r_sh   <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_a_sh   <= w_a_next;
            r_b_sh   <= w_b_next;
            r_r_sh   <= w_r_next;
            r_br     <= w_br_next;
            r_cnt    <= w_cnt_next;
            r_diff   <= w_diff_next;
            r_borrow <= w_borrow_next;
            r_ovf    <= w_ovf_next;
        end
    end

    assign bus.busy   = (r_state != StIdle);
    assign bus.done   = (r_state == StDone);
    assign bus.diff   = r_diff;
    assign bus.borrow = r_borrow;
    assign bus.ovf    = r_ovf;
endmodule
